// File: rtl/spart_driver_if.sv
// spart_driver_if: SPART register-bus control and status pins shared by driver and SPART
// Signals: iocs (chip select strobe), iorw (1=read), ioaddr (register select),
//          rda (receive data available), tbr (transmit buffer ready).
// The 8-bit databus stays a plain inout port on the driver so tristate resolution is top-level.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// spart_driver: CPU stand-in that programs the SPART baud divisor and echoes received bytes
// Ports: clk, rst (sync, active-high); br_cfg baud select from switches;
//        bus (master modport: iocs/iorw/ioaddr out, rda/tbr in); databus shared 8-bit bus;
//        echo_cnt bytes echoed (wrapping); last_byte most recent byte read.
module spart_driver #(
  parameter logic [15:0] DIV_0 = 16'd10416,
  parameter logic [15:0] DIV_1 = 16'd5208,
  parameter logic [15:0] DIV_2 = 16'd2604,
  parameter logic [15:0] DIV_3 = 16'd1302
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            br_cfg,
  spart_driver_if.master        bus,
  inout  wire  [7:0]            databus,
  output logic [15:0]           echo_cnt,
  output logic [7:0]            last_byte
);
  typedef enum logic [2:0] {INIT_LO, GAP1, INIT_HI, IDLE, READ, WAIT_TBR, WRITE} state_t;
  state_t state_q, state_d;
  logic [1:0] br_q;
  logic [7:0] wdata_q, wdata_d, last_q;
  logic [15:0] echo_q, div_cfg, div_q;
  logic acc, wr;
  function automatic logic [15:0] div_of(input logic [1:0] s);
    return s == 2'd0 ? DIV_0 : s == 2'd1 ? DIV_1 : s == 2'd2 ? DIV_2 : DIV_3;
  endfunction
  assign div_cfg = div_of(br_cfg);
  assign div_q = div_of(br_q);
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_LO:  state_d = GAP1;
      GAP1:     state_d = INIT_HI;
      INIT_HI:  state_d = IDLE;
      IDLE:     state_d = br_cfg != br_q ? INIT_LO : bus.rda ? READ : IDLE;
      READ:     state_d = WAIT_TBR;
      WAIT_TBR: state_d = bus.tbr ? WRITE : WAIT_TBR;
      default:  state_d = IDLE;
    endcase
  end
  // Write data is loaded for the state being entered so it is stable for the whole strobe.
  // The low divisor byte uses br_cfg directly because br_q is latched on the same edge.
  assign wdata_d = state_d == INIT_LO ? div_cfg[7:0] : state_d == INIT_HI ? div_q[15:8] : last_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_LO;
      br_q    <= br_cfg;
      wdata_q <= div_cfg[7:0];
      echo_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      if (state_d == INIT_LO) br_q <= br_cfg;
      if (state_q == READ) last_q <= databus;
      if (state_q == WRITE) echo_q <= echo_q + 16'd1;
    end
  end
  // Gating the strobe with rst makes a reset abort an in-flight access with no partial write.
  assign acc = !rst && (state_q inside {INIT_LO, INIT_HI, READ, WRITE});
  assign wr = acc && state_q != READ;
  assign bus.iocs = acc;
  assign bus.iorw = !wr;
  assign bus.ioaddr = !acc ? 2'b00 : state_q == INIT_LO ? 2'b10 : state_q == INIT_HI ? 2'b11 : 2'b00;
  assign databus = wr ? wdata_q : 8'hzz;
  assign echo_cnt = echo_q;
  assign last_byte = last_q;
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: directed self-checking bench for spart_driver with a simple SPART bus model
module tb_spart_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic [7:0] spart_data = 8'h00;
  wire [7:0] databus;
  wire [15:0] echo_cnt;
  wire [7:0] last_byte;
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_echo = 16'd0;
  spart_driver_if bus();
  spart_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .bus(bus.master),
    .databus(databus), .echo_cnt(echo_cnt), .last_byte(last_byte)
  );
  // SPART side: drives read data during reads and 00 on idle cycles, so a stray driver write shows up.
  assign databus = (bus.iocs && !bus.iorw) ? 8'hzz : (bus.iocs ? spart_data : 8'h00);
  wire [11:0] bv = {bus.iocs, bus.iorw, bus.ioaddr, databus};
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; br_cfg = 2'b01; bus.rda = 1'b0; bus.tbr = 1'b0;
    cyc; cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL reset_bus: got %h want %h", bv, 12'h400); end
    tests++; if ({echo_cnt, last_byte} !== 24'h0) begin fails++; $display("FAIL reset_regs: got %h want %h", {echo_cnt, last_byte}, 24'h0); end
    rst = 1'b0; #1;
    tests++; if (bv !== 12'hA58) begin fails++; $display("FAIL init_lo: got %h want %h", bv, 12'hA58); end
    cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL init_gap: got %h want %h", bv, 12'h400); end
    cyc;
    tests++; if (bv !== 12'hB14) begin fails++; $display("FAIL init_hi: got %h want %h", bv, 12'hB14); end
    cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL init_idle: got %h want %h", bv, 12'h400); end
    cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL idle_hold: got %h want %h", bv, 12'h400); end
  endtask

  task automatic test_single_echo;
    spart_data = 8'h41; bus.tbr = 1'b1; bus.rda = 1'b1;
    cyc; bus.rda = 1'b0;
    tests++; if (bv !== 12'hC41) begin fails++; $display("FAIL echo_read: got %h want %h", bv, 12'hC41); end
    cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL echo_wait: got %h want %h", bv, 12'h400); end
    tests++; if (last_byte !== 8'h41) begin fails++; $display("FAIL echo_last: got %h want %h", last_byte, 8'h41); end
    cyc;
    tests++; if (bv !== 12'h841) begin fails++; $display("FAIL echo_write: got %h want %h", bv, 12'h841); end
    cyc; exp_echo++; bus.tbr = 1'b0;
    tests++; if (echo_cnt !== exp_echo) begin fails++; $display("FAIL echo_count: got %0d want %0d", echo_cnt, exp_echo); end
  endtask

  task automatic test_back_pressure;
    int hi = 0;
    spart_data = 8'h5A; bus.tbr = 1'b0; bus.rda = 1'b1;
    cyc; bus.rda = 1'b0;
    tests++; if (bv !== 12'hC5A) begin fails++; $display("FAIL bp_read: got %h want %h", bv, 12'hC5A); end
    repeat (20) begin cyc; if (bus.iocs) hi++; end
    tests++; if (hi !== 0) begin fails++; $display("FAIL bp_quiet: got %0d strobes want 0", hi); end
    bus.tbr = 1'b1;
    cyc; bus.tbr = 1'b0;
    tests++; if (bv !== 12'h85A) begin fails++; $display("FAIL bp_write: got %h want %h", bv, 12'h85A); end
    cyc; exp_echo++;
    tests++; if (echo_cnt !== exp_echo) begin fails++; $display("FAIL bp_count: got %0d want %0d", echo_cnt, exp_echo); end
  endtask

  task automatic test_baud_change;
    br_cfg = 2'b11;
    cyc;
    tests++; if (bv !== 12'hA16) begin fails++; $display("FAIL baud_lo: got %h want %h", bv, 12'hA16); end
    cyc; cyc;
    tests++; if (bv !== 12'hB05) begin fails++; $display("FAIL baud_hi: got %h want %h", bv, 12'hB05); end
    cyc; cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL baud_settle: got %h want %h", bv, 12'h400); end
    spart_data = 8'h33; bus.rda = 1'b1; bus.tbr = 1'b0;
    cyc; bus.rda = 1'b0; br_cfg = 2'b01;
    tests++; if (bv !== 12'hC33) begin fails++; $display("FAIL defer_read: got %h want %h", bv, 12'hC33); end
    cyc; cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL defer_wait: got %h want %h", bv, 12'h400); end
    bus.tbr = 1'b1;
    cyc; bus.tbr = 1'b0;
    tests++; if (bv !== 12'h833) begin fails++; $display("FAIL defer_write: got %h want %h", bv, 12'h833); end
    cyc; exp_echo++;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL defer_idle: got %h want %h", bv, 12'h400); end
    cyc;
    tests++; if (bv !== 12'hA58) begin fails++; $display("FAIL defer_lo: got %h want %h", bv, 12'hA58); end
    cyc; cyc;
    tests++; if (bv !== 12'hB14) begin fails++; $display("FAIL defer_hi: got %h want %h", bv, 12'hB14); end
    cyc;
  endtask

  task automatic test_simultaneous;
    br_cfg = 2'b10; spart_data = 8'h77; bus.rda = 1'b1; bus.tbr = 1'b1;
    cyc;
    tests++; if (bv !== 12'hA2C) begin fails++; $display("FAIL simul_lo: got %h want %h", bv, 12'hA2C); end
    cyc; cyc;
    tests++; if (bv !== 12'hB0A) begin fails++; $display("FAIL simul_hi: got %h want %h", bv, 12'hB0A); end
    cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL simul_idle: got %h want %h", bv, 12'h400); end
    cyc; bus.rda = 1'b0;
    tests++; if (bv !== 12'hC77) begin fails++; $display("FAIL simul_read: got %h want %h", bv, 12'hC77); end
    cyc; cyc;
    tests++; if (bv !== 12'h877) begin fails++; $display("FAIL simul_write: got %h want %h", bv, 12'h877); end
    cyc; exp_echo++;
  endtask

  task automatic test_back_to_back;
    spart_data = 8'h11; bus.rda = 1'b1; bus.tbr = 1'b1;
    cyc;
    tests++; if (bv !== 12'hC11) begin fails++; $display("FAIL b2b_read1: got %h want %h", bv, 12'hC11); end
    cyc; cyc;
    tests++; if (bv !== 12'h811) begin fails++; $display("FAIL b2b_write1: got %h want %h", bv, 12'h811); end
    spart_data = 8'h22;
    cyc; exp_echo++;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL b2b_gap: got %h want %h", bv, 12'h400); end
    cyc; bus.rda = 1'b0;
    tests++; if (bv !== 12'hC22) begin fails++; $display("FAIL b2b_read2: got %h want %h", bv, 12'hC22); end
    cyc; cyc;
    tests++; if (bv !== 12'h822) begin fails++; $display("FAIL b2b_write2: got %h want %h", bv, 12'h822); end
    cyc; exp_echo++;
    tests++; if (echo_cnt !== exp_echo) begin fails++; $display("FAIL b2b_count: got %0d want %0d", echo_cnt, exp_echo); end
  endtask

  task automatic test_hygiene;
    int dbl = 0, bad = 0, writes = 0;
    logic prev = 1'b0;
    logic [7:0] mb = 8'h22;
    for (int i = 0; i < 1010; i++) begin
      cyc;
      if (bus.iocs && prev) dbl++;
      prev = bus.iocs;
      if (bus.iocs && bus.iorw) begin
        if (databus !== spart_data || bus.ioaddr !== 2'b00) bad++;
        mb = spart_data;
      end else if (bus.iocs) begin
        if (databus !== mb || bus.ioaddr !== 2'b00) bad++;
        writes++;
      end else if (databus !== 8'h00) bad++;
      bus.rda = i < 1000 ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.tbr = i < 1000 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!(bus.iocs && bus.iorw)) spart_data = 8'($urandom_range(1, 255));
    end
    exp_echo += 16'(writes);
    tests++; if (dbl !== 0) begin fails++; $display("FAIL hyg_double: got %0d back-to-back strobes want 0", dbl); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL hyg_bus: got %0d bad bus cycles want 0", bad); end
    tests++; if (echo_cnt !== exp_echo) begin fails++; $display("FAIL hyg_count: got %0d want %0d", echo_cnt, exp_echo); end
    tests++; if (last_byte !== mb) begin fails++; $display("FAIL hyg_last: got %h want %h", last_byte, mb); end
    tests++; if (writes < 50) begin fails++; $display("FAIL hyg_traffic: got %0d writes want >=50", writes); end
  endtask

  task automatic test_reset_mid;
    spart_data = 8'h99; bus.rda = 1'b1; bus.tbr = 1'b0;
    cyc; bus.rda = 1'b0;
    tests++; if (bv !== 12'hC99) begin fails++; $display("FAIL rmid_read: got %h want %h", bv, 12'hC99); end
    cyc;
    rst = 1'b1; br_cfg = 2'b00;
    cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL rmid_bus: got %h want %h", bv, 12'h400); end
    tests++; if ({echo_cnt, last_byte} !== 24'h0) begin fails++; $display("FAIL rmid_regs: got %h want %h", {echo_cnt, last_byte}, 24'h0); end
    rst = 1'b0; #1;
    tests++; if (bv !== 12'hAB0) begin fails++; $display("FAIL rmid_lo: got %h want %h", bv, 12'hAB0); end
    rst = 1'b1; #1;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL rmid_abort: got %h want %h", bv, 12'h400); end
    cyc; rst = 1'b0; #1;
    tests++; if (bv !== 12'hAB0) begin fails++; $display("FAIL rmid_relo: got %h want %h", bv, 12'hAB0); end
    cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL rmid_gap: got %h want %h", bv, 12'h400); end
    cyc;
    tests++; if (bv !== 12'hB28) begin fails++; $display("FAIL rmid_hi: got %h want %h", bv, 12'hB28); end
    cyc;
    tests++; if (bv !== 12'h400) begin fails++; $display("FAIL rmid_idle: got %h want %h", bv, 12'h400); end
  endtask

  initial begin
    bus.rda = 1'b0;
    bus.tbr = 1'b0;
    test_reset;
    test_single_echo;
    test_back_pressure;
    test_baud_change;
    test_simultaneous;
    test_back_to_back;
    test_hygiene;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
